// File: rtl/bus_arbiter_param_if.sv
// bus_arbiter_param_if: request/grant bundle between the bus masters and the
// arbiter. The master modport is the requester side; the slave modport is
// the side the arbiter plugs into.
interface bus_arbiter_param_if #(
  parameter int NUM_MASTERS = 2
);
  localparam int ID_W = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] breq;
  logic [NUM_MASTERS-1:0] bgrant;
  logic [ID_W-1:0]        bgrant_id;
  logic                   bus_busy;
  logic                   preempt;

  modport master (
    output breq,
    input  bgrant,
    input  bgrant_id,
    input  bus_busy,
    input  preempt
  );

  modport slave (
    input  breq,
    output bgrant,
    output bgrant_id,
    output bus_busy,
    output preempt
  );
endinterface

// File: rtl/bus_arbiter_param.sv
// bus_arbiter_param: N-master system bus arbiter, fixed priority (master 0
// highest) or round-robin. The owner keeps the bus for its whole tenure; one
// dead cycle separates consecutive owners.
// Optional tenure limit with forced release: define ARB_TENURE_LIMIT_EN.
module bus_arbiter_param #(
  parameter int NUM_MASTERS = 2,
  parameter int RR_MODE     = 0,
  parameter int MAX_TENURE  = 16
) (
  input  logic               clk,
  input  logic               rstn,
  bus_arbiter_param_if.slave bus
);

  localparam int ID_W = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || MAX_TENURE < 1 || MAX_TENURE > 255) begin : g_param_check
    $error("bus_arbiter_param: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    TURN
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic                   busy_q, busy_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;

  logic [NUM_MASTERS-1:0] req_eff;
  logic                   owner_req;
  logic                   win_found;
  logic [ID_W-1:0]        win_idx;
  logic [ID_W-1:0]        cand;

  assign owner_req = |(bus.breq & grant_q);

`ifdef ARB_TENURE_LIMIT_EN
  localparam logic [7:0] TENURE_LAST = 8'(MAX_TENURE - 1);

  logic [7:0]             tenure_q, tenure_d;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;
  logic                   preempt_q, preempt_d;
  logic                   others_req;

  assign others_req  = |(bus.breq & ~grant_q);
  // A master that was just forced off sits out the arbitration that follows.
  assign req_eff     = bus.breq & ~mask_q;
  assign bus.preempt = preempt_q;
`else
  assign req_eff     = bus.breq;
  assign bus.preempt = 1'b0;
`endif

  assign bus.bgrant    = grant_q;
  assign bus.bgrant_id = id_q;
  assign bus.bus_busy  = busy_q;

  // Pick the winner among eligible requests: lowest index, or first at/above the RR pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (RR_MODE != 0) begin
        cand = ID_W'((int'(ptr_q) + i) % NUM_MASTERS);
        if (!win_found && req_eff[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end else if (!win_found && req_eff[i]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
  end

  // Next-state and next-output logic; the closing edge of TURN is also an arbitration point.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
`ifdef ARB_TENURE_LIMIT_EN
    tenure_d  = tenure_q;
    mask_d    = mask_q;
    preempt_d = 1'b0;
`endif
    case (state_q)
      IDLE, TURN: begin
        state_d = IDLE;
`ifdef ARB_TENURE_LIMIT_EN
        mask_d = '0;
`endif
        if (win_found) begin
          state_d = OWNED;
          grant_d = NUM_MASTERS'(1) << win_idx;
          id_d    = win_idx;
          busy_d  = 1'b1;
          if (RR_MODE != 0) begin
            ptr_d = (win_idx == ID_W'(NUM_MASTERS - 1)) ? '0 : win_idx + ID_W'(1);
          end
`ifdef ARB_TENURE_LIMIT_EN
          tenure_d = '0;
`endif
        end
      end
      OWNED: begin
        if (!owner_req) begin
          state_d = TURN;
          grant_d = '0;
          id_d    = '0;
          busy_d  = 1'b0;
        end
`ifdef ARB_TENURE_LIMIT_EN
        else if (tenure_q == TENURE_LAST && others_req) begin
          state_d   = TURN;
          grant_d   = '0;
          id_d      = '0;
          busy_d    = 1'b0;
          preempt_d = 1'b1;
          mask_d    = grant_q;
        end else if (tenure_q != TENURE_LAST) begin
          tenure_d = tenure_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears the bus immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TENURE_LIMIT_EN
  // Tenure counter, one-shot arbitration mask and preempt pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tenure_q  <= '0;
      mask_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      tenure_q  <= tenure_d;
      mask_q    <= mask_d;
      preempt_q <= preempt_d;
    end
  end
`endif

endmodule
